// File: rtl/dlx_pipe_if.sv
// DLX instruction-fetch stage: PC, IF/ID pipeline register and RUN/HALT/TRAP control.
// Optional fetch counter output if_fetch_cnt is built only with DLX_IF_FETCH_CNT_EN defined.
module dlx_pipe_if #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter logic [31:0] BUBBLE_IR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        dc_wait,
  input  logic        id_cond,
  input  logic [31:0] id_npc,
  input  logic        id_illegal_instr,
  input  logic        id_halt,
  output logic [31:0] ic_addr,
  output logic        ic_en,
  input  logic [31:0] ic_data,
  input  logic        ic_wait,
  output logic [31:0] if_id_npc,
  output logic [31:0] if_id_ir,
  output logic [1:0]  if_state
`ifdef DLX_IF_FETCH_CNT_EN
  ,
  output logic [31:0] if_fetch_cnt
`endif
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_HALT = 2'd1;
  localparam logic [1:0] S_TRAP = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_inc;

  assign pc_inc   = pc + 32'd4;
  assign ic_addr  = pc;
  assign ic_en    = (state == S_RUN);
  assign if_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_RUN;
      pc        <= RESET_PC;
      if_id_ir  <= BUBBLE_IR;
      if_id_npc <= RESET_PC;
    end else begin
      case (state)
        S_RUN: begin
          if (id_halt) begin
            state    <= S_HALT;
            if_id_ir <= BUBBLE_IR;
          end else if (id_illegal_instr) begin
            state    <= S_TRAP;
            pc       <= TRAP_VEC;
            if_id_ir <= BUBBLE_IR;
          end else if (stall || dc_wait) begin
            // frozen pipe: a pending branch is retaken once the stall clears
          end else if (id_cond) begin
            pc        <= {id_npc[31:2], 2'b00};
            if_id_ir  <= BUBBLE_IR;
            if_id_npc <= id_npc;
          end else if (ic_wait) begin
            if_id_ir <= BUBBLE_IR;
          end else begin
            pc        <= pc_inc;
            if_id_ir  <= ic_data;
            if_id_npc <= pc_inc;
          end
        end
        S_TRAP: begin
          // one dead cycle; pc already holds TRAP_VEC
          state    <= S_RUN;
          if_id_ir <= BUBBLE_IR;
        end
        S_HALT: begin
          if_id_ir <= BUBBLE_IR;
        end
        default: begin
          state    <= S_RUN;
          if_id_ir <= BUBBLE_IR;
        end
      endcase
    end
  end

`ifdef DLX_IF_FETCH_CNT_EN
  logic seq_fetch;

  assign seq_fetch = (state == S_RUN) && !id_halt && !id_illegal_instr &&
                     !stall && !dc_wait && !id_cond && !ic_wait;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_fetch_cnt <= 32'd0;
    end else if (seq_fetch) begin
      if_fetch_cnt <= if_fetch_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dlx_pipe_if.sv
// Directed bench for dlx_pipe_if: a behavioural model pushes expected outputs, checked after each edge.
module tb_dlx_pipe_if;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam logic [31:0] BUBBLE_IR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, dc_wait, id_cond, id_illegal_instr, id_halt, ic_wait;
  logic [31:0] id_npc, ic_data, ic_addr, if_id_npc, if_id_ir;
  logic        ic_en;
  logic [1:0]  if_state;
`ifdef DLX_IF_FETCH_CNT_EN
  logic [31:0] if_fetch_cnt;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  assign ic_data = mem(ic_addr);

  dlx_pipe_if #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC), .BUBBLE_IR(BUBBLE_IR)) dut (
    .clk(clk), .rst(rst), .stall(stall), .dc_wait(dc_wait), .id_cond(id_cond),
    .id_npc(id_npc), .id_illegal_instr(id_illegal_instr), .id_halt(id_halt),
    .ic_addr(ic_addr), .ic_en(ic_en), .ic_data(ic_data), .ic_wait(ic_wait),
    .if_id_npc(if_id_npc), .if_id_ir(if_id_ir), .if_state(if_state)
`ifdef DLX_IF_FETCH_CNT_EN
    , .if_fetch_cnt(if_fetch_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] ir;
    logic [31:0] npc;
    logic [1:0]  st;
    logic        en;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] m_pc, m_ir, m_npc, m_cnt;
  logic [1:0]  m_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, model the next state, check after the rising edge.
  task automatic cyc(input logic r, input logic s, input logic d, input logic c,
                     input logic [31:0] n, input logic ill, input logic h, input logic w);
    exp_t e;
    rst = r; stall = s; dc_wait = d; id_cond = c; id_npc = n;
    id_illegal_instr = ill; id_halt = h; ic_wait = w;
    if (!r) begin
      m_pc = RESET_PC; m_st = 2'd0; m_ir = BUBBLE_IR; m_npc = RESET_PC; m_cnt = 32'd0;
    end else if (m_st == 2'd0) begin
      if (h) begin
        m_st = 2'd1; m_ir = BUBBLE_IR;
      end else if (ill) begin
        m_st = 2'd2; m_pc = TRAP_VEC; m_ir = BUBBLE_IR;
      end else if (s || d) begin
        m_pc = m_pc;
      end else if (c) begin
        m_pc = n & 32'hFFFF_FFFC; m_ir = BUBBLE_IR; m_npc = n;
      end else if (w) begin
        m_ir = BUBBLE_IR;
      end else begin
        m_ir = mem(m_pc); m_pc = m_pc + 32'd4; m_npc = m_pc; m_cnt = m_cnt + 32'd1;
      end
    end else if (m_st == 2'd2) begin
      m_st = 2'd0;
    end
    e.addr = m_pc; e.ir = m_ir; e.npc = m_npc; e.st = m_st;
    e.en = (m_st == 2'd0); e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    chk("ic_addr",   ic_addr,            e.addr);
    chk("if_id_ir",  if_id_ir,           e.ir);
    chk("if_id_npc", if_id_npc,          e.npc);
    chk("if_state",  {30'd0, if_state},  {30'd0, e.st});
    chk("ic_en",     {31'd0, ic_en},     {31'd0, e.en});
`ifdef DLX_IF_FETCH_CNT_EN
    chk("fetch_cnt", if_fetch_cnt,       e.cnt);
`endif
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 0; stall = 0; dc_wait = 0; id_cond = 0; id_npc = 0;
    id_illegal_instr = 0; id_halt = 0; ic_wait = 0;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 32'h44, 0, 1, 1);
    chk("reset_ir", if_id_ir, BUBBLE_IR);

    // sequential fetches 0,4,8
    run(3);
    chk("seq_npc3", if_id_npc, 32'd12);
    chk("seq_ir3",  if_id_ir,  mem(32'd8));
    run(2);
    // taken branch to 0x40
    cyc(1, 0, 0, 1, 32'h40, 0, 0, 0);
    chk("br_addr", ic_addr, 32'h40);
    chk("br_npc",  if_id_npc, 32'h40);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
`ifdef DLX_IF_FETCH_CNT_EN
    chk("cnt5", if_fetch_cnt, 32'd5);
`endif

    // stall and dc_wait freeze over a pending branch
    cyc(1, 1, 0, 1, 32'h80, 0, 0, 1);
    cyc(1, 1, 0, 1, 32'h80, 0, 0, 0);
    chk("stall_addr", ic_addr, 32'h40);
    cyc(1, 0, 1, 1, 32'h80, 0, 0, 0);
    cyc(1, 0, 0, 1, 32'h80, 0, 0, 1);
    chk("post_stall_br", ic_addr, 32'h80);

    // ic_wait for 3 cycles then resume
    run(1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 1);
    run(2);
    chk("resume_ir", if_id_ir, mem(32'h88));

    // unaligned target and PC wrap
    cyc(1, 0, 0, 1, 32'h0000_0043, 0, 0, 0);
    chk("align_addr", ic_addr, 32'h40);
    cyc(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    run(1);
    chk("wrap_addr", ic_addr, 32'h0);

    // illegal instruction: one TRAP cycle ignoring other inputs
    cyc(1, 0, 0, 1, 32'h200, 1, 0, 0);
    chk("trap_state", {30'd0, if_state}, 32'd2);
    cyc(1, 1, 1, 1, 32'h300, 0, 0, 1);
    chk("trap_ret", ic_addr, TRAP_VEC);
    run(2);

    // halt persists until reset, id_halt outranks illegal
    cyc(1, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 32'h500, 0, 0, 0);
    cyc(1, 1, 1, 1, 32'h500, 1, 0, 1);
    run(2);
    chk("halt_en", {31'd0, ic_en}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rel_en", {31'd0, ic_en}, 32'd1);
    run(2);

    // reset in the middle of a stall
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 32'h60, 0, 0, 0);
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
